// File: rtl/serbus_pkg.sv
// Shared constants for the serial bus transmitter: FSM encodings, the
// symbol/quarter structure of a frame, and the bus levels each quarter drives.
package serbus_pkg;

   localparam int unsigned QCYC_DEFAULT = 2;
   localparam int unsigned NUM_QUARTERS = 4;
   localparam int unsigned NUM_SYMBOLS  = 6;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_BIT3  = 3'd2;
   localparam logic [2:0] ST_BIT2  = 3'd3;
   localparam logic [2:0] ST_BIT1  = 3'd4;
   localparam logic [2:0] ST_BIT0  = 3'd5;
   localparam logic [2:0] ST_STOP  = 3'd6;

   localparam logic [1:0] PHASE_LAST = 2'(NUM_QUARTERS - 1);

   // Bus levels {scl, sda} for a given symbol state and quarter phase.
   // bitVal is the data bit carried by a BITn symbol and is ignored elsewhere.
   function automatic logic [1:0] busLevels(input logic [2:0] state,
                                            input logic [1:0] phase,
                                            input logic       bitVal);
      logic [1:0] levels;
      levels = 2'b11;
      case (state)
         ST_START: begin
            if (phase == 2'd0)      levels = 2'b11;
            else if (phase == 2'd1) levels = 2'b10;
            else                    levels = 2'b00;
         end
         ST_BIT3, ST_BIT2, ST_BIT1, ST_BIT0: begin
            levels = {phase[1], bitVal};
         end
         ST_STOP: begin
            if (phase == 2'd2)      levels = 2'b10;
            else if (phase == 2'd3) levels = 2'b11;
            else                    levels = 2'b00;
         end
         default: levels = 2'b11;
      endcase
      return levels;
   endfunction

endpackage

// File: rtl/qtick_gen.sv
// Quarter-bit tick generator: pulses tick_o for one cycle every QCYC cycles,
// counting from zero as soon as rst_i is released.
module qtick_gen
   import serbus_pkg::*;
#(
   parameter int unsigned QCYC = QCYC_DEFAULT
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic tick_o
);

   localparam logic [7:0] LAST = 8'(QCYC - 1);

   logic [7:0] count_q;
   logic [7:0] count_d;

   // Next count wraps on the last cycle of each quarter.
   always_comb begin
      count_d = count_q + 8'd1;
      if (count_q == LAST) begin
         count_d = 8'd0;
      end
   end

   // Counter register, held at zero while the transmitter is idle or in reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tick_o = (count_q == LAST) && !rst_i;

endmodule

// File: rtl/ptosda.sv
// Parallel-to-serial transmitter: sends a 4-bit frame MSB first as
// START, BIT3..BIT0, STOP symbols of four quarters each on a registered scl/sda pair.
module ptosda
   import serbus_pkg::*;
#(
   parameter int unsigned QCYC = QCYC_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       valid,
   input  logic [3:0] data,
   output logic       ready,
   output logic       done,
   output logic       scl,
   output logic       sda
);

   logic [2:0] state_q, state_d;
   logic [1:0] phase_q, phase_d;
   logic [3:0] shift_q, shift_d;
   logic       scl_q, scl_d;
   logic       sda_q, sda_d;
   logic       done_q, done_d;
   logic       quarterTick;
   logic       tickRst;

   assign tickRst = rst || (state_q == ST_IDLE);

   qtick_gen #(
      .QCYC(QCYC)
   ) uQtick (
      .clk_i (clk),
      .rst_i (tickRst),
      .tick_o(quarterTick)
   );

   // Next-state logic: accept in IDLE, advance phase on each quarter tick and
   // the symbol on the phase wrap; bus levels are derived from the next state
   // so they change on the very edge that enters a quarter.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      shift_d = shift_q;
      done_d  = 1'b0;
      if (state_q == ST_IDLE) begin
         if (valid) begin
            state_d = ST_START;
            phase_d = 2'd0;
            shift_d = data;
         end
      end else if (quarterTick) begin
         if (phase_q == PHASE_LAST) begin
            phase_d = 2'd0;
            case (state_q)
               ST_START: state_d = ST_BIT3;
               ST_BIT3: begin
                  state_d = ST_BIT2;
                  shift_d = {shift_q[2:0], 1'b0};
               end
               ST_BIT2: begin
                  state_d = ST_BIT1;
                  shift_d = {shift_q[2:0], 1'b0};
               end
               ST_BIT1: begin
                  state_d = ST_BIT0;
                  shift_d = {shift_q[2:0], 1'b0};
               end
               ST_BIT0: state_d = ST_STOP;
               ST_STOP: begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
               default: state_d = ST_IDLE;
            endcase
         end else begin
            phase_d = phase_q + 2'd1;
         end
      end
      {scl_d, sda_d} = busLevels(state_d, phase_d, shift_d[3]);
   end

   // State and bus registers; reset aborts any frame and releases the bus high.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         phase_q <= 2'd0;
         shift_q <= 4'd0;
         scl_q   <= 1'b1;
         sda_q   <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         shift_q <= shift_d;
         scl_q   <= scl_d;
         sda_q   <= sda_d;
         done_q  <= done_d;
      end
   end

   assign ready = (state_q == ST_IDLE);
   assign done  = done_q;
   assign scl   = scl_q;
   assign sda   = sda_q;

endmodule

// File: tb/tb_ptosda.sv
// Testbench for ptosda: two instances (QCYC=2 and QCYC=1) checked every cycle
// against a timing model of the frame, plus hand-computed waveform points.
module tb_ptosda;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0] rstV   = 2'b11;
   logic [1:0] validV = 2'b00;
   logic [1:0] readyV, doneV, sclV, sdaV;
   logic [3:0] dataV [2] = '{4'h0, 4'h0};

   ptosda #(.QCYC(2)) dut2 (
      .clk(clk), .rst(rstV[0]), .valid(validV[0]), .data(dataV[0]),
      .ready(readyV[0]), .done(doneV[0]), .scl(sclV[0]), .sda(sdaV[0])
   );

   ptosda #(.QCYC(1)) dut1 (
      .clk(clk), .rst(rstV[1]), .valid(validV[1]), .data(dataV[1]),
      .ready(readyV[1]), .done(doneV[1]), .scl(sclV[1]), .sda(sdaV[1])
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   int         mStart  [2] = '{-1, -1};
   int         mDoneAt [2] = '{-1, -1};
   logic [3:0] mData   [2] = '{4'h0, 4'h0};
   bit         mValid  [2] = '{1'b0, 1'b0};

   logic [3:0] trace [2][0:1023];

   // Expected {ready, done, scl, sda} at cycle t from the frame's start cycle:
   // the symbol and quarter follow from plain division of the elapsed time.
   function automatic logic [3:0] expectOut(int q, int st, logic [3:0] d, int doneAt, int t);
      int off, sym, qu;
      logic b;
      if (st >= 0 && t >= st) begin
         off = t - st;
         sym = off / (4 * q);
         qu  = (off / q) % 4;
         case (sym)
            0: return (qu == 0) ? 4'b0011 : (qu == 1) ? 4'b0010 : 4'b0000;
            1, 2, 3, 4: begin
               b = d[4 - sym];
               return {2'b00, (qu >= 2), b};
            end
            default: return (qu < 2) ? 4'b0000 : (qu == 2) ? 4'b0010 : 4'b0011;
         endcase
      end
      return {1'b1, (t == doneAt), 2'b11};
   endfunction

   task automatic applyStimulus(input int k, input logic r, input logic v, input logic [3:0] d);
      rstV[k]   = r;
      validV[k] = v;
      dataV[k]  = d;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   // scl rising edge at cycle c with the given sda level
   task automatic checkRise(input string name, input int k, input int c, input logic expSda);
      checkOutput(name, int'({trace[k][c-1][1], trace[k][c][1], trace[k][c][0]}),
                  int'({2'b01, expSda}));
   endtask

   int a;
   int n;

   initial begin
      fork
         // Model update at each edge, using the inputs of the cycle that ends.
         forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
               int q;
               q = (k == 0) ? 2 : 1;
               if (rstV[k]) begin
                  mStart[k]  = -1;
                  mDoneAt[k] = -1;
                  mValid[k]  = 1'b1;
               end else if (mStart[k] >= 0) begin
                  if (cyc == mStart[k] + 24 * q - 1) begin
                     mStart[k]  = -1;
                     mDoneAt[k] = cyc + 1;
                  end
               end else if (validV[k]) begin
                  mStart[k] = cyc + 1;
                  mData[k]  = dataV[k];
               end
            end
            cyc = cyc + 1;
         end
         // Mid-cycle compare of every output against the model, with tracing.
         forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
               logic [3:0] act, exp;
               act = {readyV[k], doneV[k], sclV[k], sdaV[k]};
               if (cyc < 1024) trace[k][cyc] = act;
               if (mValid[k]) begin
                  exp = expectOut((k == 0) ? 2 : 1, mStart[k], mData[k], mDoneAt[k], cyc);
                  vectors++;
                  if (act !== exp) begin
                     miscompares++;
                     $display("[TB] FAIL model%0d cyc %0d {ready,done,scl,sda}: got %b, want %b",
                              k, cyc, act, exp);
                  end
               end
            end
         end
      join_none

      // Reset state
      waitCycles(2);
      applyStimulus(0, 1'b0, 1'b0, 4'h0);
      applyStimulus(1, 1'b0, 1'b0, 4'h0);
      waitCycles(1);
      checkOutput("reset0", int'(trace[0][cyc-1]), int'(4'b1011));
      checkOutput("reset1", int'(trace[1][cyc-1]), int'(4'b1011));

      // Single frame 4'b1010
      a = cyc;
      applyStimulus(0, 1'b0, 1'b1, 4'b1010);
      waitCycles(1);
      applyStimulus(0, 1'b0, 1'b0, 4'h0);
      waitCycles(60);
      checkOutput("startSdaFall", int'({trace[0][a+2][0], trace[0][a+3][0], trace[0][a+3][1]}), 3'b101);
      checkOutput("startSclFall", int'({trace[0][a+4][1], trace[0][a+5][1]}), 2'b10);
      checkRise("bit3", 0, a + 13, 1'b1);
      checkRise("bit2", 0, a + 21, 1'b0);
      checkRise("bit1", 0, a + 29, 1'b1);
      checkRise("bit0", 0, a + 37, 1'b0);
      checkRise("stopRise", 0, a + 45, 1'b0);
      checkOutput("stopSdaRise", int'({trace[0][a+46][0], trace[0][a+47][0], trace[0][a+47][1]}), 3'b011);
      checkOutput("doneAt49", int'({trace[0][a+48][2], trace[0][a+49][2], trace[0][a+49][3]}), 3'b011);
      n = 0;
      for (int i = a + 4; i <= a + 46; i++)
         if (trace[0][i][1] && trace[0][i-1][1] && (trace[0][i][0] != trace[0][i-1][0])) n++;
      checkOutput("noSdaEdgeSclHigh", n, 0);

      // Back-to-back frames with valid held high, data changed mid-frame
      a = cyc;
      applyStimulus(0, 1'b0, 1'b1, 4'h0);
      waitCycles(1);
      applyStimulus(0, 1'b0, 1'b1, 4'hF);
      waitCycles(49);
      applyStimulus(0, 1'b0, 1'b0, 4'hF);
      waitCycles(60);
      checkRise("b2bFirstBit3", 0, a + 13, 1'b0);
      checkRise("b2bFirstBit0", 0, a + 37, 1'b0);
      checkOutput("b2bDone", int'(trace[0][a+49][2]), 1);
      checkOutput("b2bStartFall", int'({trace[0][a+51][0], trace[0][a+52][0], trace[0][a+52][1]}), 3'b101);
      checkRise("b2bBit3", 0, a + 62, 1'b1);
      checkRise("b2bBit2", 0, a + 70, 1'b1);
      checkRise("b2bBit1", 0, a + 78, 1'b1);
      checkRise("b2bBit0", 0, a + 86, 1'b1);

      // valid pulse mid-frame is ignored
      a = cyc;
      applyStimulus(0, 1'b0, 1'b1, 4'h3);
      waitCycles(1);
      applyStimulus(0, 1'b0, 1'b0, 4'h3);
      waitCycles(19);
      applyStimulus(0, 1'b0, 1'b1, 4'h5);
      waitCycles(1);
      applyStimulus(0, 1'b0, 1'b0, 4'h5);
      waitCycles(45);
      checkRise("ignBit3", 0, a + 13, 1'b0);
      checkRise("ignBit2", 0, a + 21, 1'b0);
      checkRise("ignBit1", 0, a + 29, 1'b1);
      checkRise("ignBit0", 0, a + 37, 1'b1);
      n = 0;
      for (int i = a + 50; i <= a + 65; i++)
         if (trace[0][i] != 4'b1011) n++;
      checkOutput("noSecondFrame", n, 0);

      // Reset mid-frame, then a fresh frame
      a = cyc;
      applyStimulus(0, 1'b0, 1'b1, 4'h9);
      waitCycles(1);
      applyStimulus(0, 1'b0, 1'b0, 4'h9);
      waitCycles(24);
      applyStimulus(0, 1'b1, 1'b0, 4'h9);
      waitCycles(1);
      applyStimulus(0, 1'b0, 1'b0, 4'h9);
      waitCycles(1);
      applyStimulus(0, 1'b0, 1'b1, 4'h6);
      waitCycles(1);
      applyStimulus(0, 1'b0, 1'b0, 4'h6);
      waitCycles(55);
      checkOutput("rstIdle", int'(trace[0][a+26]), int'(4'b1011));
      n = 0;
      for (int i = a + 1; i <= a + 75; i++)
         if (trace[0][i][2]) n++;
      checkOutput("rstNoDone", n, 0);
      checkRise("rstBit3", 0, a + 40, 1'b0);
      checkRise("rstBit2", 0, a + 48, 1'b1);
      checkRise("rstBit1", 0, a + 56, 1'b1);
      checkRise("rstBit0", 0, a + 64, 1'b0);
      checkOutput("rstDone", int'(trace[0][a+76][2]), 1);

      // QCYC=1 frame 4'hF
      a = cyc;
      applyStimulus(1, 1'b0, 1'b1, 4'hF);
      waitCycles(1);
      applyStimulus(1, 1'b0, 1'b0, 4'hF);
      waitCycles(30);
      checkOutput("q1StartQ0", int'(trace[1][a+1]), int'(4'b0011));
      checkRise("q1Bit3", 1, a + 7, 1'b1);
      checkOutput("q1StopSdaRise", int'({trace[1][a+23][0], trace[1][a+24][0], trace[1][a+24][1]}), 3'b011);
      checkOutput("q1Busy24", int'({trace[1][a+24][3], trace[1][a+24][2]}), 2'b00);
      checkOutput("q1Done25", int'({trace[1][a+25][3], trace[1][a+25][2]}), 2'b11);
      checkOutput("q1Done26", int'(trace[1][a+26][2]), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
